mdio_master: RTL
================

// Module: mdio_master
// PURPOSE
//  Clause-22 MDIO management master: accepts one read/write command, generates MDC from clk,
//  serialises preamble/ST/OP/PHYAD/REGAD/TA/DATA on mdio_o/mdio_t, returns read data.
//  Upstream of the PHY MDIO slave; tristate pins split as discrete mdio_o/mdio_t/mdio_i.
// PARAMETERS
//  CLK_DIV        10  clk cycles per MDC half-period (>=2); MDC period = 2*CLK_DIV clk cycles
//  PREAMBLE_BITS  32  number of '1' preamble bits (1..32)
// PORTS
//  clk           in   1   system clock; all logic on posedge clk
//  reset_n       in   1   synchronous, active-low reset
//  cmd_valid     in   1   command request
//  cmd_ready     out  1   high in IDLE only; accept on cmd_valid && cmd_ready
//  cmd_opcode    in   2   2'b01 write, 2'b10 read; others illegal
//  cmd_phy_addr  in   5   PHY address
//  cmd_reg_addr  in   5   register address
//  cmd_wr_data   in   16  write data (ignored for read)
//  rsp_valid     out  1   1-cycle pulse at end of command
//  rsp_error     out  1   valid with rsp_valid; 1 = illegal opcode, no frame sent
//  rsp_rd_data   out  16  read data, valid with rsp_valid (0 for write/error); held until next rsp
//  mdc           out  1   management clock
//  mdio_o        out  1   MDIO drive value
//  mdio_t        out  1   MDIO tristate: 1 = released (high-Z), 0 = driving mdio_o
//  mdio_i        in   1   MDIO sampled value
// BEHAVIOUR
//  Reset (reset_n=0, any state incl. mid-frame): state IDLE, mdc=0, mdio_t=1, mdio_o=0,
//   cmd_ready=1, rsp_valid=0, rsp_error=0, rsp_rd_data=0, div counter and bit counter cleared.
//  Command fields registered on accept; changes on inputs while busy have no effect.
//  Bit period: CLK_DIV cycles mdc=0 then CLK_DIV cycles mdc=1. mdio_o/mdio_t update on the first
//   cycle of each low phase (MDC fall); slave samples on MDC rise.
//  Frame = PREAMBLE_BITS + 32 bit periods: PRE(1s), ST=01, OP, PHYAD[4:0], REGAD[4:0] MSB first,
//   TA, DATA[15:0] MSB first. First bit period starts the cycle after accept.
//  Write: mdio_t=0 entire frame; TA driven 1,0; DATA=cmd_wr_data.
//  Read: mdio_t=0 through REGAD[0]; mdio_t=1 from first TA period to frame end. mdio_i sampled
//   on last high-phase cycle of each DATA period, shifted in MSB first.
//  States: IDLE -> PREAMBLE -> HEADER(ST,OP,PHYAD,REGAD: 14 bits) -> TA(2) -> DATA(16) -> DONE -> IDLE.
//   DONE lasts 1 cycle: rsp_valid=1, mdc=0, mdio_t=1; cmd_ready returns 1 next cycle.
//  Latency: rsp_valid at cycle (PREAMBLE_BITS+32)*2*CLK_DIV + 1 after accept cycle.
//  Illegal opcode (00/11): accepted, no MDC toggles, mdio_t stays 1; rsp_valid+rsp_error the
//   cycle after accept.
//  cmd_valid while busy: not accepted (cmd_ready=0), no side effect; back-to-back commands may be
//   accepted the cycle after DONE.
//  MDC held 0 in IDLE/DONE; never toggles outside a frame; no glitches (registered output).
//  Bit counter 6 bits, counts down per field; div counter wraps CLK_DIV-1 -> 0 generating strobes.
// STRUCTURE
//  mdio_pkg: MDIO_OP_WRITE=2'b01, MDIO_OP_READ=2'b10, MDIO_START=2'b01, MDIO_TA_WRITE=2'b10,
//   field widths (PHYAD/REGAD 5, DATA 16), mdio_master_state_t enum.
//  Sub-module mdio_clk_gen: CLK_DIV divider, enable input, outputs mdc, mdc_rise/mdc_fall strobes.
//  Top: FSM, bit counter, 16-bit TX/RX shift registers.
// TESTING (bench pairs with MDIO slave BFM: PHY 5'h0c, reg 5'h18, data 16'haaa5)
//  1 read op=10 phy=0x0c reg=0x18 -> BFM opcode=10, phy_addr=0x0c, reg_addr=0x18,
//    turnaround_valid=1; rsp_rd_data=16'haaa5, rsp_error=0, mdio_t=1 during TA and DATA.
//  2 write op=01 phy=0x03 reg=0x04 data=0x1234 -> monitor decodes 32x1, 01, 01, 00011, 00100,
//    10, 0x1234; mdio_t=0 whole frame; rsp_valid at accept+64*2*CLK_DIV+1.
//  3 CLK_DIV=4, PREAMBLE_BITS=32 -> MDC period 8 clk, exactly 64 rising edges per frame, mdc=0 idle.
//  4 cmd_valid held during frame with different fields -> ignored; second command accepted cycle
//    after rsp_valid, frame matches its own fields.
//  5 reset_n=0 for 1 cycle mid-DATA of a read -> next cycle mdc=0, mdio_t=1, cmd_ready=1,
//    no rsp_valid; a following read returns 16'haaa5.
//  6 op=11 -> rsp_valid=1, rsp_error=1 at accept+1; zero MDC edges, mdio_t stays 1.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared constants, field widths and the FSM state type for the Clause-22 MDIO master.
package mdio_pkg;

  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_START    = 2'b01;
  localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

  localparam int MDIO_PHYAD_W  = 5;
  localparam int MDIO_REGAD_W  = 5;
  localparam int MDIO_DATA_W   = 16;
  localparam int MDIO_HDR_BITS = 2 + 2 + MDIO_PHYAD_W + MDIO_REGAD_W;
  localparam int MDIO_TA_BITS  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_TA,
    ST_DATA,
    ST_DONE
  } mdio_master_state_t;

  function automatic logic mdio_op_legal(input logic [1:0] op);
    return (op == MDIO_OP_WRITE) || (op == MDIO_OP_READ);
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: CLK_DIV clk cycles low then CLK_DIV high while enabled, held low otherwise.
// Strobes flag the last clk cycle before the corresponding MDC edge.
module mdio_clk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_mdc,
  output logic o_mdc_rise,
  output logic o_mdc_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_mdc;
  logic             w_wrap;

  assign w_wrap = i_en && (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n || !i_en) begin
      r_div <= '0;
      r_mdc <= 1'b0;
    end else if (w_wrap) begin
      r_div <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign o_mdc      = r_mdc;
  assign o_mdc_rise = w_wrap && !r_mdc;
  assign o_mdc_fall = w_wrap && r_mdc;

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one read/write command per frame, MDC from clk, split tristate pins.
// All frame state advances on the end-of-bit strobe, so mdio_o/mdio_t change only at MDC fall.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV       = 10,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_opcode,
  input  logic [MDIO_PHYAD_W-1:0] cmd_phy_addr,
  input  logic [MDIO_REGAD_W-1:0] cmd_reg_addr,
  input  logic [MDIO_DATA_W-1:0]  cmd_wr_data,
  output logic                    rsp_valid,
  output logic                    rsp_error,
  output logic [MDIO_DATA_W-1:0]  rsp_rd_data,
  output logic                    mdc,
  output logic                    mdio_o,
  output logic                    mdio_t,
  input  logic                    mdio_i
);

  mdio_master_state_t r_state, w_next_state;

  logic [5:0]             r_bit_cnt;
  logic [MDIO_DATA_W-1:0] r_tx_shift;
  logic [MDIO_DATA_W-1:0] r_rx_shift;
  logic [MDIO_DATA_W-1:0] r_wr_data;
  logic [MDIO_DATA_W-1:0] r_rsp_rd_data;
  logic                   r_is_read;
  logic                   r_err;

  logic                   w_accept;
  logic                   w_legal;
  logic                   w_clk_en;
  logic                   w_bit_end;
  logic                   w_unused_rise;
  logic                   w_cnt_zero;
  logic [5:0]             w_cnt_reload;
  logic [MDIO_DATA_W-1:0] w_rx_next;

  assign w_accept   = cmd_valid && (r_state == ST_IDLE);
  assign w_legal    = mdio_op_legal(cmd_opcode);
  assign w_clk_en   = r_state inside {ST_PREAMBLE, ST_HEADER, ST_TA, ST_DATA};
  assign w_cnt_zero = (r_bit_cnt == 6'd0);
  assign w_rx_next  = {r_rx_shift[MDIO_DATA_W-2:0], mdio_i};

  mdio_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (w_clk_en),
    .o_mdc     (mdc),
    .o_mdc_rise(w_unused_rise),
    .o_mdc_fall(w_bit_end)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (cmd_valid) w_next_state = w_legal ? ST_PREAMBLE : ST_DONE;
      ST_PREAMBLE: if (w_bit_end && w_cnt_zero) w_next_state = ST_HEADER;
      ST_HEADER:   if (w_bit_end && w_cnt_zero) w_next_state = ST_TA;
      ST_TA:       if (w_bit_end && w_cnt_zero) w_next_state = ST_DATA;
      ST_DATA:     if (w_bit_end && w_cnt_zero) w_next_state = ST_DONE;
      ST_DONE:     w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Bit counter holds (bits left in field - 1); reload value is the length of the following field.
  always_comb begin
    w_cnt_reload = 6'd0;
    case (r_state)
      ST_PREAMBLE: w_cnt_reload = 6'(MDIO_HDR_BITS - 1);
      ST_HEADER:   w_cnt_reload = 6'(MDIO_TA_BITS - 1);
      ST_TA:       w_cnt_reload = 6'(MDIO_DATA_W - 1);
      default:     w_cnt_reload = 6'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bit_cnt     <= '0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_wr_data     <= '0;
      r_rsp_rd_data <= '0;
      r_is_read     <= 1'b0;
      r_err         <= 1'b0;
    end else if (w_accept) begin
      r_tx_shift <= {MDIO_START, cmd_opcode, cmd_phy_addr, cmd_reg_addr, MDIO_TA_WRITE};
      r_wr_data  <= cmd_wr_data;
      r_is_read  <= (cmd_opcode == MDIO_OP_READ);
      r_err      <= !w_legal;
      r_bit_cnt  <= 6'(PREAMBLE_BITS - 1);
      r_rx_shift <= '0;
      if (!w_legal) r_rsp_rd_data <= '0;
    end else if (w_bit_end) begin
      r_bit_cnt <= w_cnt_zero ? w_cnt_reload : r_bit_cnt - 6'd1;
      if (r_state == ST_TA && w_cnt_zero) begin
        r_tx_shift <= r_wr_data;
      end else if (r_state != ST_PREAMBLE) begin
        r_tx_shift <= {r_tx_shift[MDIO_DATA_W-2:0], 1'b0};
      end
      if (r_state == ST_DATA) begin
        r_rx_shift <= w_rx_next;
        if (w_cnt_zero) r_rsp_rd_data <= r_is_read ? w_rx_next : '0;
      end
    end
  end

  // A read releases the line from the first turnaround bit to the end of the frame.
  always_comb begin
    mdio_o = 1'b0;
    mdio_t = 1'b1;
    case (r_state)
      ST_PREAMBLE: begin
        mdio_o = 1'b1;
        mdio_t = 1'b0;
      end
      ST_HEADER: begin
        mdio_o = r_tx_shift[MDIO_DATA_W-1];
        mdio_t = 1'b0;
      end
      ST_TA, ST_DATA: begin
        if (!r_is_read) begin
          mdio_o = r_tx_shift[MDIO_DATA_W-1];
          mdio_t = 1'b0;
        end
      end
      default: begin
        mdio_o = 1'b0;
        mdio_t = 1'b1;
      end
    endcase
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_DONE);
  assign rsp_error   = (r_state == ST_DONE) && r_err;
  assign rsp_rd_data = r_rsp_rd_data;

endmodule
